minute_counter: RTL

MINUTE_COUNTER -- requirements
Module: minute_counter

---
 rtl/minute_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/minute_counter.sv
// Minute stage of a BCD clock: counts 00..59 on ticks from the seconds stage,
// supports manual set (inc/dec with wrap) and a validated parallel load.
module minute_counter #(
    parameter int unsigned TICK_EDGE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       set_mode,
    input  logic       set_inc,
    input  logic       set_dec,
    input  logic       load_en,
    input  logic [2:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] min_1,
    output logic [2:0] min_10,
    output logic       hour_tick,
    output logic       load_err,
    output logic       in_set
);

    typedef enum logic [0:0] {StRun, StSet} state_e;

    state_e     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [2:0] tens_q, tens_d;
    logic       hour_tick_q, hour_tick_d;
    logic       load_err_q, load_err_d;
    logic       tick_ev;

    logic [3:0] inc_ones, dec_ones;
    logic [2:0] inc_tens, dec_tens;
    logic       at_59;
    logic       load_ok;

    if (TICK_EDGE != 0) begin : g_edge
        logic tick_q;
        // Tick history is captured even in reset so a held-high tick never counts on release.
        always_ff @(posedge clk) begin
            tick_q <= tick_in;
        end
        assign tick_ev = tick_in & ~tick_q;
    end else begin : g_level
        assign tick_ev = tick_in;
    end

    // Candidate +1 / -1 values with 59<->00 wrap, and load validation.
    always_comb begin
        at_59    = (tens_q == 3'd5) && (ones_q == 4'd9);
        inc_ones = ones_q + 4'd1;
        inc_tens = tens_q;
        if (ones_q >= 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = (tens_q >= 3'd5) ? 3'd0 : tens_q + 3'd1;
        end
        dec_ones = ones_q - 4'd1;
        dec_tens = tens_q;
        if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = (tens_q == 3'd0) ? 3'd5 : tens_q - 3'd1;
        end
        load_ok = (load_tens <= 3'd5) && (load_ones <= 4'd9);
    end

    // Next-state: load wins over everything; otherwise RUN counts ticks, SET takes inc/dec.
    always_comb begin
        ones_d      = ones_q;
        tens_d      = tens_q;
        hour_tick_d = 1'b0;
        load_err_d  = 1'b0;
        state_d     = set_mode ? StSet : StRun;
        if (load_en) begin
            if (load_ok) begin
                ones_d = load_ones;
                tens_d = load_tens;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (tick_ev) begin
                        ones_d      = inc_ones;
                        tens_d      = inc_tens;
                        hour_tick_d = at_59;
                    end
                end
                StSet: begin
                    if (set_inc && !set_dec) begin
                        ones_d = inc_ones;
                        tens_d = inc_tens;
                    end else if (set_dec && !set_inc) begin
                        ones_d = dec_ones;
                        tens_d = dec_tens;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            ones_q      <= 4'd0;
            tens_q      <= 3'd0;
            hour_tick_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            hour_tick_q <= hour_tick_d;
            load_err_q  <= load_err_d;
        end
    end

    assign min_1     = ones_q;
    assign min_10    = tens_q;
    assign hour_tick = hour_tick_q;
    assign load_err  = load_err_q;
    assign in_set    = (state_q == StSet);

endmodule
